// File: rtl/id_ex_reg_pkg.sv
// Shared pipe definitions: RV32 opcodes, control-bundle layout and the
// source-operand usage rules used by hazard logic in ID/EX and IF/ID.
package id_ex_reg_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // Bundle is packed MSB-first in decoder order: RegDst at bit 23 down to Concat_control[2:0].
  localparam int CTRL_W         = 24;
  localparam int CTRL_REGDST    = 23;
  localparam int CTRL_JUMP      = 22;
  localparam int CTRL_BRANCH    = 21;
  localparam int CTRL_MEMREAD   = 20;
  localparam int CTRL_MEMTOREG  = 19;
  localparam int CTRL_ALUOP     = 12;
  localparam int CTRL_ALUOP_W   = 7;
  localparam int CTRL_MEMWRITE  = 11;
  localparam int CTRL_ALUSRC1   = 10;
  localparam int CTRL_ALUSRC2   = 9;
  localparam int CTRL_REGWRITE  = 8;
  localparam int CTRL_JALORJALR = 7;
  localparam int CTRL_BE        = 3;
  localparam int CTRL_BE_W      = 4;
  localparam int CTRL_CONCAT    = 0;
  localparam int CTRL_CONCAT_W  = 3;

  typedef struct packed {
    logic       reg_dst;
    logic       jump;
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic [6:0] alu_op;
    logic       mem_write;
    logic       alu_src1;
    logic       alu_src2;
    logic       reg_write;
    logic       jal_or_jalr;
    logic [3:0] be;
    logic [2:0] concat_control;
  } ctrl_t;

  function automatic logic [CTRL_ALUOP_W-1:0] ctrl_aluop(input logic [CTRL_W-1:0] c);
    return c[CTRL_ALUOP +: CTRL_ALUOP_W];
  endfunction

  function automatic logic rs1_used(input logic [6:0] op);
    return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
  endfunction

  function automatic logic rs2_used(input logic [6:0] op);
    return (op == OP_R || op == OP_STORE || op == OP_BRANCH);
  endfunction

endpackage

// File: rtl/id_ex_reg_if.sv
// ID->EX bus: decoder outputs and pipeline controls in, registered EX slot,
// IF/ID stall and bubble counter out.
interface id_ex_reg_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  import id_ex_reg_pkg::*;

  logic              id_valid;
  logic [CTRL_W-1:0] id_ctrl;
  logic [XLEN-1:0]   id_pc;
  logic [XLEN-1:0]   id_rs1_data;
  logic [XLEN-1:0]   id_rs2_data;
  logic [XLEN-1:0]   id_imm;
  logic [4:0]        id_rs1;
  logic [4:0]        id_rs2;
  logic [4:0]        id_rd;
  logic [2:0]        id_funct3;
  logic              id_funct7b5;
  logic              flush;
  logic              freeze;

  logic              ex_valid;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [XLEN-1:0]   ex_pc;
  logic [XLEN-1:0]   ex_rs1_data;
  logic [XLEN-1:0]   ex_rs2_data;
  logic [XLEN-1:0]   ex_imm;
  logic [4:0]        ex_rs1;
  logic [4:0]        ex_rs2;
  logic [4:0]        ex_rd;
  logic [2:0]        ex_funct3;
  logic              ex_funct7b5;
  logic              stall_if;
  logic [CNT_W-1:0]  bubble_count;

  modport master (
    output id_valid, id_ctrl, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1, id_rs2, id_rd, id_funct3, id_funct7b5, flush, freeze,
    input  ex_valid, ex_ctrl, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
           ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7b5, stall_if, bubble_count
  );

  modport slave (
    input  id_valid, id_ctrl, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1, id_rs2, id_rd, id_funct3, id_funct7b5, flush, freeze,
    output ex_valid, ex_ctrl, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
           ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7b5, stall_if, bubble_count
  );

endinterface

// File: rtl/id_ex_reg_hazard_detect.sv
// Load-use hazard detection: an ID instruction reading the destination of a
// load sitting in EX must wait one cycle. Purely combinational.
module hazard_detect
  import id_ex_reg_pkg::*;
(
  input  logic              id_valid,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic              ex_valid,
  input  logic [CTRL_W-1:0] ex_ctrl,
  input  logic [4:0]        ex_rd,
  input  logic              flush,
  input  logic              freeze,
  output logic              load_use,
  output logic              stall_if
);

  logic [6:0] id_op;
  logic       ex_is_load;
  logic       src_hit;

  // ALUOp carries the raw opcode; MemRead/MemtoReg cannot identify loads.
  assign id_op      = ctrl_aluop(id_ctrl);
  assign ex_is_load = ex_valid && (ctrl_aluop(ex_ctrl) == OP_LOAD);
  assign src_hit    = (rs1_used(id_op) && (id_rs1 == ex_rd)) ||
                      (rs2_used(id_op) && (id_rs2 == ex_rd));

  assign load_use = id_valid && ex_is_load && (ex_rd != 5'd0) && src_hit;
  // A flush kills the dependent instruction, so no stall is needed for it.
  assign stall_if = (load_use && !flush) || freeze;

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use bubble insertion, EX flush and a
// global freeze. Counts inserted load-use bubbles (saturating).
module id_ex_reg
  import id_ex_reg_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic        CLK,
  input  logic        RST,
  id_ex_reg_if.slave  bus
);

  logic              valid_q,    valid_d;
  logic [CTRL_W-1:0] ctrl_q,     ctrl_d;
  logic [XLEN-1:0]   pc_q,       pc_d;
  logic [XLEN-1:0]   rs1_data_q, rs1_data_d;
  logic [XLEN-1:0]   rs2_data_q, rs2_data_d;
  logic [XLEN-1:0]   imm_q,      imm_d;
  logic [4:0]        rs1_q,      rs1_d;
  logic [4:0]        rs2_q,      rs2_d;
  logic [4:0]        rd_q,       rd_d;
  logic [2:0]        funct3_q,   funct3_d;
  logic              funct7b5_q, funct7b5_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;

  logic load_use;
  logic stall_if;

  hazard_detect u_hazard (
    .id_valid (bus.id_valid),
    .id_ctrl  (bus.id_ctrl),
    .id_rs1   (bus.id_rs1),
    .id_rs2   (bus.id_rs2),
    .ex_valid (valid_q),
    .ex_ctrl  (ctrl_q),
    .ex_rd    (rd_q),
    .flush    (bus.flush),
    .freeze   (bus.freeze),
    .load_use (load_use),
    .stall_if (stall_if)
  );

  always_comb begin
    valid_d    = valid_q;
    ctrl_d     = ctrl_q;
    pc_d       = pc_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    funct3_d   = funct3_q;
    funct7b5_d = funct7b5_q;
    cnt_d      = cnt_q;
    if (!bus.freeze) begin
      // Datapath fields are don't-care in a bubble, so they always follow ID.
      pc_d       = bus.id_pc;
      rs1_data_d = bus.id_rs1_data;
      rs2_data_d = bus.id_rs2_data;
      imm_d      = bus.id_imm;
      rs1_d      = bus.id_rs1;
      rs2_d      = bus.id_rs2;
      rd_d       = bus.id_rd;
      funct3_d   = bus.id_funct3;
      funct7b5_d = bus.id_funct7b5;
      if (bus.flush || load_use) begin
        valid_d = 1'b0;
        ctrl_d  = '0;
        if (!bus.flush && (cnt_q != {CNT_W{1'b1}}))
          cnt_d = cnt_q + 1'b1;
      end else begin
        valid_d = bus.id_valid;
        ctrl_d  = bus.id_valid ? bus.id_ctrl : '0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q    <= 1'b0;
      ctrl_q     <= '0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      funct3_q   <= '0;
      funct7b5_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      ctrl_q     <= ctrl_d;
      pc_q       <= pc_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      funct3_q   <= funct3_d;
      funct7b5_q <= funct7b5_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.ex_valid     = valid_q;
  assign bus.ex_ctrl      = ctrl_q;
  assign bus.ex_pc        = pc_q;
  assign bus.ex_rs1_data  = rs1_data_q;
  assign bus.ex_rs2_data  = rs2_data_q;
  assign bus.ex_imm       = imm_q;
  assign bus.ex_rs1       = rs1_q;
  assign bus.ex_rs2       = rs2_q;
  assign bus.ex_rd        = rd_q;
  assign bus.ex_funct3    = funct3_q;
  assign bus.ex_funct7b5  = funct7b5_q;
  assign bus.stall_if     = stall_if;
  assign bus.bubble_count = cnt_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Scoreboard bench for id_ex_reg: directed pipeline scenarios then random
// traffic, compared against a behavioural model of the EX slot.
module tb_id_ex_reg;
  import id_ex_reg_pkg::*;

  localparam int XLEN    = 32;
  localparam int CNT_W   = 4;   // small counter so saturation is reachable
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  id_ex_reg_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();
  id_ex_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  typedef struct {
    bit        valid;
    bit [23:0] ctrl;
    bit        dp_chk;   // datapath known (not a bubble's don't-care)
    bit [31:0] pc, rs1d, rs2d, imm;
    bit [4:0]  rs1, rs2, rd;
    bit [2:0]  f3;
    bit        f7;
    int        cnt;
  } ex_t;

  ex_t model;
  bit  model_known = 0;
  ex_t exp_q[$];
  int  errors = 0;
  int  checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    ex_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("ex_valid", bus.ex_valid, e.valid);
      chk("ex_ctrl", bus.ex_ctrl, e.ctrl);
      chk("bubble_count", bus.bubble_count, e.cnt);
      if (e.dp_chk) begin
        chk("ex_pc", bus.ex_pc, e.pc);
        chk("ex_rs1_data", bus.ex_rs1_data, e.rs1d);
        chk("ex_rs2_data", bus.ex_rs2_data, e.rs2d);
        chk("ex_imm", bus.ex_imm, e.imm);
        chk("ex_idx", {bus.ex_rs1, bus.ex_rs2, bus.ex_rd, bus.ex_funct3, bus.ex_funct7b5},
            {e.rs1, e.rs2, e.rd, e.f3, e.f7});
      end
    end
  end

  // Model: does the instruction in ID read the destination of a load in EX?
  function automatic bit model_load_use(bit v, bit [6:0] op, bit [4:0] rs1, bit [4:0] rs2);
    ctrl_t mc;
    bit r1, r2;
    mc = model.ctrl;
    r1 = !(op inside {OP_LUI, OP_AUIPC, OP_JAL});
    r2 = op inside {OP_R, OP_STORE, OP_BRANCH};
    return v && model.valid && mc.alu_op == OP_LOAD && model.rd != 0 &&
           ((r1 && rs1 == model.rd) || (r2 && rs2 == model.rd));
  endfunction

  task automatic step(input bit rst, input bit v, input bit [6:0] op,
                      input bit [4:0] rs1, input bit [4:0] rs2, input bit [4:0] rd,
                      input bit [31:0] pc, input bit fl, input bit fz);
    ctrl_t cs;
    ex_t   n;
    bit    lu;
    @(negedge CLK);
    #1;
    cs = ctrl_t'($urandom_range(0, 24'hFFFFFF));
    cs.alu_op = op;
    RST             = rst;
    bus.id_valid    = v;
    bus.id_ctrl     = cs;
    bus.id_pc       = pc;
    bus.id_rs1_data = $urandom;
    bus.id_rs2_data = $urandom;
    bus.id_imm      = $urandom;
    bus.id_rs1      = rs1;
    bus.id_rs2      = rs2;
    bus.id_rd       = rd;
    bus.id_funct3   = 3'($urandom_range(0, 7));
    bus.id_funct7b5 = 1'($urandom_range(0, 1));
    bus.flush       = fl;
    bus.freeze      = fz;
    #1;
    lu = model_load_use(v, op, rs1, rs2);
    if (model_known) chk("stall_if", bus.stall_if, (lu && !fl) || fz);
    n = model;
    if (rst) begin
      n = '{default: 0};
      n.dp_chk = 1;
    end else if (fz) begin
      n = model;
    end else if (fl || lu) begin
      n.valid = 0; n.ctrl = 0; n.dp_chk = 0;
      if (lu && !fl && n.cnt < CNT_MAX) n.cnt++;
    end else begin
      n.valid = v; n.ctrl = v ? 24'(cs) : 24'h0; n.dp_chk = 1;
      n.pc = pc; n.rs1d = bus.id_rs1_data; n.rs2d = bus.id_rs2_data; n.imm = bus.id_imm;
      n.rs1 = rs1; n.rs2 = rs2; n.rd = rd; n.f3 = bus.id_funct3; n.f7 = bus.id_funct7b5;
    end
    model = n;
    if (rst) model_known = 1;
    if (model_known) exp_q.push_back(n);
  endtask

  bit [6:0] ops [9];

  initial begin
    ops = '{OP_LUI, OP_AUIPC, OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR};
    model = '{default: 0};
    RST = 1; bus.flush = 0; bus.freeze = 0; bus.id_valid = 0; bus.id_ctrl = 0;
    // reset
    step(1, 0, OP_R, 0, 0, 0, 32'h0, 0, 0);
    step(1, 0, OP_R, 0, 0, 0, 32'h0, 0, 0);
    // independent ADDs
    step(0, 1, OP_R, 1, 2, 3, 32'h00, 0, 0);
    step(0, 1, OP_R, 1, 2, 4, 32'h04, 0, 0);
    // LW x5 then dependent ADD: one bubble, then the ADD proceeds
    step(0, 1, OP_LOAD, 1, 0, 5, 32'h08, 0, 0);
    step(0, 1, OP_R, 5, 1, 6, 32'h0C, 0, 0);
    step(0, 1, OP_R, 5, 1, 6, 32'h0C, 0, 0);
    // x0 destination and LUI never stall
    step(0, 1, OP_LOAD, 1, 0, 0, 32'h10, 0, 0);
    step(0, 1, OP_R, 0, 1, 6, 32'h14, 0, 0);
    step(0, 1, OP_LOAD, 1, 0, 5, 32'h18, 0, 0);
    step(0, 1, OP_LUI, 5, 5, 5, 32'h1C, 0, 0);
    // flush, and flush coinciding with load-use
    step(0, 1, OP_R, 1, 2, 3, 32'h20, 1, 0);
    step(0, 1, OP_LOAD, 1, 0, 5, 32'h24, 0, 0);
    step(0, 1, OP_R, 5, 1, 6, 32'h28, 1, 0);
    // freeze for 3 cycles with ID changing, then release
    step(0, 1, OP_R, 1, 2, 3, 32'h40, 0, 0);
    step(0, 1, OP_I, 2, 0, 7, 32'h44, 0, 1);
    step(0, 1, OP_STORE, 3, 4, 0, 32'h48, 1, 1);
    step(0, 0, OP_R, 1, 2, 3, 32'h4C, 0, 1);
    step(0, 1, OP_R, 7, 8, 9, 32'h80, 0, 0);
    // reset while a load-use stall is active
    step(0, 1, OP_LOAD, 1, 0, 5, 32'h84, 0, 0);
    step(1, 1, OP_R, 5, 1, 6, 32'h88, 0, 0);
    step(0, 1, OP_R, 5, 1, 6, 32'h88, 0, 0);
    // drive the counter into saturation
    for (int i = 0; i < CNT_MAX + 4; i++) begin
      step(0, 1, OP_LOAD, 2, 0, 5, 32'h100 + 32'(8 * i), 0, 0);
      step(0, 1, OP_BRANCH, 1, 5, 0, 32'h104 + 32'(8 * i), 0, 0);
    end
    // random traffic on a small register set to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      bit [6:0] op;
      op = ($urandom_range(0, 9) < 3) ? OP_LOAD : ops[$urandom_range(0, 8)];
      step($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0, op,
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           $urandom, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
    end
    @(negedge CLK);
    @(negedge CLK);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
